// File: rtl/ff_fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
package ff_fifo_reader_pkg;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Width of the transferred-word statistics counter.
  localparam int WORD_COUNT_W = 32;

  // Beat counter width: $clog2(len), never narrower than one bit.
  function automatic int beat_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/ff_fifo_reader_skid.sv
// Two-entry skid buffer between a registered-flag FIFO and a valid/ready
// stream. Pops whenever a slot is free or about to be freed, so the stream
// sustains one word per cycle while fully absorbing backpressure.
module ff_fifo_reader_skid
  import ff_fifo_reader_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             xfer
);

  skid_state_e      state_q, state_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign xfer      = out_valid && out_ready;
  // Held low during reset so nothing is dequeued into a buffer being cleared.
  assign fifo_pop  = rst_n && !fifo_empty && (state_q != TWO || out_ready);

  // Next occupancy and buffer contents from this cycle's pop and transfer.
  always_comb begin
    // NOTE: every always_comb target gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (fifo_pop) begin
          state_d = ONE;
          head_d  = fifo_read_data;
        end
      end
      ONE: begin
        if (fifo_pop && xfer) begin
          head_d = fifo_read_data;
        end else if (fifo_pop) begin
          state_d = TWO;
          tail_d  = fifo_read_data;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // A pop in TWO implies out_ready, and out_valid is set, so pop
        // always coincides with a transfer here.
        if (xfer) begin
          head_d = tail_q;
          if (fifo_pop) begin
            tail_d = fifo_read_data;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy register; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Word storage; contents are only meaningful while the state says so.
  always_ff @(posedge clk) begin
    // NOTE: data registers deliberately have no reset; occupancy alone
    // qualifies them, which keeps reset fan-out off the datapath.
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/ff_fifo_stream_reader.sv
// FIFO-to-stream reader: skid buffer plus burst framing (out_last) and an
// optional transferred-word counter enabled by FF_FIFO_READER_STATS_EN.
// Without the macro word_count is tied to zero; ports are identical.
module ff_fifo_stream_reader
  import ff_fifo_reader_pkg::*;
#(
  parameter int width     = 8,
  parameter int burst_len = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  input  logic [width-1:0]        fifo_read_data,
  output logic                    fifo_pop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width-1:0]        out_data,
  output logic                    out_last,
  output logic [WORD_COUNT_W-1:0] word_count
);

  localparam int                BEAT_W    = beat_width(burst_len);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_len - 1);

  logic              xfer;
  logic [BEAT_W-1:0] beat_q, beat_d;

  ff_fifo_reader_skid #(.width(width)) u_skid (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .xfer           (xfer)
  );

  assign out_last = out_valid && (beat_q == LAST_BEAT);

  // Beat position within the burst: advances per transfer, wraps after last.
  always_comb begin
    beat_d = beat_q;
    if (xfer) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
  end

  // Beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

`ifdef FF_FIFO_READER_STATS_EN
  logic [WORD_COUNT_W-1:0] count_q, count_d;

  // Transferred-word count, wrapping modulo 2^32.
  always_comb begin
    count_d = count_q;
    if (xfer) count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign word_count = count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: doc/ff_fifo_stream_reader.md
FF_FIFO_STREAM_READER -- requirements
Module: ff_fifo_stream_reader

Interface
REQ-001 SHALL have parameter width, default 8, the data word width in bits.
REQ-002 SHALL have parameter burst_len, default 4, the words per burst; legal range 1..256.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-005 SHALL have port fifo_empty  input  1  FIFO registered empty flag; when low, fifo_read_data holds the head word.
REQ-006 SHALL have port fifo_read_data  input  width  the FIFO head word, combinational from the FIFO read pointer.
REQ-007 SHALL have port fifo_pop  output  1  dequeues the FIFO head word in this cycle.
REQ-008 SHALL have port out_valid  output  1  downstream data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_data  output  width  downstream word.
REQ-011 SHALL have port out_last  output  1  marks the final word of each burst.
REQ-012 SHALL have port word_count  output  32  total words transferred downstream.

Function
REQ-013 SHALL hold up to 2 words in an internal buffer, with states EMPTY, ONE and TWO.
REQ-014 SHALL drive fifo_pop combinationally as !fifo_empty && (state != TWO || out_ready).
REQ-015 SHALL never pop while fifo_empty=1 and SHALL never overflow the buffer.
REQ-016 SHALL capture fifo_read_data on each pop.
REQ-017 SHALL present a word popped in cycle N on out_data with out_valid=1 in cycle N+1 when the buffer was EMPTY.
REQ-018 SHALL count a transfer as each cycle with out_valid && out_ready.
REQ-019 SHALL sustain 1 word/cycle with out_ready=1 continuously.
REQ-020 SHALL emit words in FIFO order, with no duplication and no loss.
REQ-021 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL follow these state transitions, writing pop as p and transfer as t:
- EMPTY->ONE on p.
- ONE->TWO on p&!t.
- ONE->EMPTY on !p&t.
- TWO->ONE on !p&t.
- Otherwise, hold.
REQ-023 SHALL, when p and t coincide in state TWO, shift the second word to the head and fill the tail from the FIFO.
REQ-024 SHALL keep a beat counter of $clog2(burst_len) bits, minimum 1 bit, that increments per transfer and wraps to 0 after burst_len-1.
REQ-025 SHALL drive out_last=1 when out_valid=1 and the beat counter equals burst_len-1; with burst_len=1, out_last SHALL be 1 for every valid word.
REQ-026 SHALL ignore out_ready while out_valid=0, with no transfer and no counter change.

Reset
REQ-027 SHALL, with rst_n=0, immediately set state EMPTY, out_valid=0, out_last=0, beat counter 0, word_count 0 and fifo_pop=0.
REQ-028 SHALL discard buffered words when reset is asserted mid-stream; the first word after reset release SHALL have beat 0.
REQ-029 SHALL leave buffer data registers free of reset; out_data is don't-care while out_valid=0.

Configuration
REQ-030 SHALL, with FF_FIFO_READER_STATS_EN defined, increment word_count by 1 per transfer, wrapping modulo 2^32.
REQ-031 SHALL, with FF_FIFO_READER_STATS_EN undefined, tie word_count to 0 and synthesize no counter logic; the port list SHALL be identical in both builds.

Structure
REQ-032 SHALL place the state enum (EMPTY, ONE, TWO) and the word_count width constant (32) in package ff_fifo_reader_pkg.
REQ-033 SHALL implement the 2-entry buffer and its state machine as sub-module ff_fifo_reader_skid; burst/last and stats logic SHALL reside in the top.

Verification
REQ-034 SHALL cover streaming: FIFO preloaded 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on consecutive cycles, out_last on 0x04 and 0x08, word_count=8.
REQ-035 SHALL cover backpressure: FIFO holds 0x10..0x13, out_ready=0 for 5 cycles -> exactly 2 pops occur, out_data=0x10 is held; release -> 0x10..0x13 in order.
REQ-036 SHALL cover an empty FIFO: fifo_empty=1 throughout -> fifo_pop=0 and out_valid=0 every cycle.
REQ-037 SHALL cover mid-stream reset: rst_n pulsed low after 2 transfers of 0x20..0x25 -> out_valid=0 and word_count=0 immediately; the next word after release has beat 0, with out_last on its 4th transfer.
REQ-038 SHALL cover the burst_len=1 build: every transferred word has out_last=1.
REQ-039 SHALL cover the build without FF_FIFO_READER_STATS_EN: word_count=0 after 8 transfers.
